smp_cap_mux: RTL and testbench

Multi-channel sample capture and merge block, the parametrised successor to the single-stream sample logger. It buffers up to NCH independent valid-qualified sample streams in per-channel FIFOs and drains them round-robin onto one ready/valid output stream tagged with the channel index. Capture supports an enable, a per-channel sample limit, overflow detection and a completion flag. It sits between DUT probe points and a single downstream logger or checker.

---
 rtl/smp_cap_mux.sv | 192 +++++++++++++++++++
 tb/tb_smp_cap_mux.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/smp_cap_mux.sv
// Multi-channel sample capture: per-channel FIFOs drained round-robin onto one tagged stream.
// Optional feature macro SMP_CAP_TS_EN adds a per-sample timestamp presented on out_ts.
module smp_cap_mux #(
  parameter int unsigned DW    = 32,
  parameter int unsigned NCH   = 4,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNTW  = 16,
  parameter int unsigned TSW   = 32,
  localparam int unsigned CHW  = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              smp_en,
  input  logic [CNTW-1:0]   max_cnt,
  input  logic [NCH*DW-1:0] in_data,
  input  logic [NCH-1:0]    in_vld,
  output logic [DW-1:0]     out_data,
  output logic [CHW-1:0]    out_ch,
  output logic              out_vld,
  input  logic              out_rdy,
`ifdef SMP_CAP_TS_EN
  output logic [TSW-1:0]    out_ts,
`endif
  output logic [NCH-1:0]    ovf,
  output logic              done
);

  localparam int unsigned AW = $clog2(DEPTH);
`ifdef SMP_CAP_TS_EN
  localparam int unsigned FW = DW + TSW;
`else
  localparam int unsigned FW = DW;
`endif
  localparam logic [AW:0]     PtrOne = (AW + 1)'(1);
  localparam logic [CNTW-1:0] CntOne = CNTW'(1);
  localparam logic [CHW-1:0]  LastCh = CHW'(NCH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;
  state_e state_q, state_d;

  logic [AW:0]     wr_ptr_q [NCH];
  logic [AW:0]     rd_ptr_q [NCH];
  logic [CNTW-1:0] cnt_q    [NCH];
  logic [FW-1:0]   mem_q    [NCH][DEPTH];
  logic [FW-1:0]   wr_word  [NCH];
  logic [FW-1:0]   rd_word  [NCH];
  logic [FW-1:0]   sel_word;
  logic [NCH-1:0]  ovf_q;
  logic [NCH-1:0]  empty, full, lim_ok, at_lim, push, drop, pop;
  logic [CHW-1:0]  rr_q, grant;
  logic            grant_vld, load, all_lim;
  logic [DW-1:0]   out_data_q;
  logic [CHW-1:0]  out_ch_q;
  logic            out_vld_q;

`ifdef SMP_CAP_TS_EN
  logic [TSW-1:0]  ts_q, out_ts_q;
`else
  logic [31:0]     unused_tsw;
  assign unused_tsw = 32'(TSW);
`endif

  for (genvar i = 0; i < NCH; i++) begin : g_ch
    assign empty[i]   = wr_ptr_q[i] == rd_ptr_q[i];
    assign full[i]    = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                        (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    assign at_lim[i]  = cnt_q[i] == max_cnt;
    assign lim_ok[i]  = (max_cnt == '0) || (cnt_q[i] < max_cnt);
    // Full check uses pre-edge occupancy: a same-cycle pop does not rescue the sample.
    assign push[i]    = (state_q == StRun) && in_vld[i] && !full[i] && lim_ok[i];
    assign drop[i]    = (state_q == StRun) && in_vld[i] && full[i] && lim_ok[i];
    assign pop[i]     = load && grant_vld && (grant == CHW'(i));
    assign rd_word[i] = mem_q[i][rd_ptr_q[i][AW-1:0]];
`ifdef SMP_CAP_TS_EN
    assign wr_word[i] = {ts_q, in_data[i*DW +: DW]};
`else
    assign wr_word[i] = in_data[i*DW +: DW];
`endif
  end

  assign all_lim  = (max_cnt != '0) && (&at_lim);
  assign load     = !out_vld_q || out_rdy;
  assign sel_word = rd_word[grant];

  // Round-robin: rr_q holds the first channel to consider (one past the last grant).
  always_comb begin : p_arb
    logic [CHW:0] idx;
    idx       = '0;
    grant     = '0;
    grant_vld = 1'b0;
    for (int unsigned k = 0; k < NCH; k++) begin
      idx = {1'b0, rr_q} + (CHW + 1)'(k);
      if (idx >= (CHW + 1)'(NCH)) idx = idx - (CHW + 1)'(NCH);
      if (!grant_vld && !empty[idx[CHW-1:0]]) begin
        grant_vld = 1'b1;
        grant     = idx[CHW-1:0];
      end
    end
  end

  always_comb begin : p_fsm
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (smp_en) state_d = StRun;
      StRun:   if (!smp_en || all_lim) state_d = StDrain;
      StDrain: if ((&empty) && !out_vld_q) state_d = StDone;
      StDone:  state_d = StDone;
      default: state_d = StIdle;
    endcase
    if (clr) state_d = StIdle;
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_state
    if (!rst_n) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_chan
    if (!rst_n) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q <= '0;
    end else if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      ovf_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (push[i]) begin
          wr_ptr_q[i] <= wr_ptr_q[i] + PtrOne;
          cnt_q[i]    <= cnt_q[i] + CntOne;
        end
        if (pop[i])  rd_ptr_q[i] <= rd_ptr_q[i] + PtrOne;
        if (drop[i]) ovf_q[i] <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin : p_mem
    for (int i = 0; i < NCH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= wr_word[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin : p_out
    if (!rst_n) begin
      out_data_q <= '0;
      out_ch_q   <= '0;
      out_vld_q  <= 1'b0;
      rr_q       <= '0;
`ifdef SMP_CAP_TS_EN
      out_ts_q   <= '0;
`endif
    end else if (clr) begin
      out_vld_q <= 1'b0;
    end else if (load) begin
      out_vld_q <= grant_vld;
      if (grant_vld) begin
        out_data_q <= sel_word[DW-1:0];
        out_ch_q   <= grant;
        rr_q       <= (grant == LastCh) ? '0 : grant + CHW'(1);
`ifdef SMP_CAP_TS_EN
        out_ts_q   <= sel_word[FW-1:DW];
`endif
      end
    end
  end

`ifdef SMP_CAP_TS_EN
  always_ff @(posedge clk or negedge rst_n) begin : p_ts
    if (!rst_n)                                      ts_q <= '0;
    else if (state_q == StIdle && state_d == StRun)  ts_q <= '0;
    else                                             ts_q <= ts_q + TSW'(1);
  end

  assign out_ts = out_ts_q;
`endif

  assign out_data = out_data_q;
  assign out_ch   = out_ch_q;
  assign out_vld  = out_vld_q;
  assign ovf      = ovf_q;
  assign done     = (state_q == StDone);

endmodule

// File: tb/tb_smp_cap_mux.sv
// Scoreboard bench for smp_cap_mux: directed vectors queue expected outputs, a monitor checks them.
module tb_smp_cap_mux;
  localparam int DW = 32, NCH = 4, DEPTH = 16, CNTW = 16, TSW = 32, CHW = 2;

  logic              clk = 1'b0;
  logic              rst_n, clr, smp_en, out_rdy;
  logic [CNTW-1:0]   max_cnt;
  logic [NCH*DW-1:0] in_data;
  logic [NCH-1:0]    in_vld;
  logic [DW-1:0]     out_data;
  logic [CHW-1:0]    out_ch;
  logic              out_vld, done;
  logic [NCH-1:0]    ovf;
`ifdef SMP_CAP_TS_EN
  logic [TSW-1:0]    out_ts;
`endif

  smp_cap_mux #(.DW(DW), .NCH(NCH), .DEPTH(DEPTH), .CNTW(CNTW), .TSW(TSW)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr), .smp_en(smp_en), .max_cnt(max_cnt),
    .in_data(in_data), .in_vld(in_vld), .out_data(out_data), .out_ch(out_ch),
    .out_vld(out_vld), .out_rdy(out_rdy),
`ifdef SMP_CAP_TS_EN
    .out_ts(out_ts),
`endif
    .ovf(ovf), .done(done)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  logic [CHW+DW-1:0] exp_q [$];
  logic [CHW+DW-1:0] mon_e;
  int hs_log [$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [CHW+DW-1:0] ent(input int ch, input logic [DW-1:0] d);
    logic [31:0] c;
    c = ch;
    return {c[CHW-1:0], d};
  endfunction

  // Handshake happens at the coming posedge; inputs are stable at the negedge.
  always @(negedge clk) begin
    if (rst_n && out_vld && out_rdy) begin
      hs_log.push_back(cyc);
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_out: got ch=%0d data=%0h expected none", out_ch, out_data);
      end else begin
        mon_e = exp_q.pop_front();
        check("out_ch_data", {30'd0, out_ch, out_data}, {30'd0, mon_e});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int ch, input logic [DW-1:0] d);
    in_data[ch*DW +: DW] = d;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; clr = 1'b0; smp_en = 1'b0; out_rdy = 1'b0;
    max_cnt = '0; in_data = '0; in_vld = '0;
    exp_q.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_drain(input string name, input int maxc);
    for (int i = 0; i < maxc && exp_q.size() != 0; i++) tick();
    tick();
    check(name, exp_q.size(), 0);
  endtask

  task automatic wait_done(input string name, input int maxc);
    for (int i = 0; i < maxc && done !== 1'b1; i++) tick();
    check(name, done, 1);
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; smp_en = 1'b0; out_rdy = 1'b0;
    max_cnt = '0; in_data = '0; in_vld = '0;
    #3;
    check("rst_out_vld", out_vld, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_ch", out_ch, 0);
    check("rst_ovf", ovf, 0);
    check("rst_done", done, 0);

    // 1: single channel stream, latency and back-to-back throughput
    do_reset();
    smp_en = 1'b1; out_rdy = 1'b1;
    tick();
    hs_log.delete();
    for (int n = 0; n < 4; n++) begin
      in_vld = 4'b0001;
      set_ch(0, 32'hA0 + n);
      exp_q.push_back(ent(0, 32'hA0 + n));
      tick();
      if (n == 0) check("t1_vld_at_push_edge", out_vld, 0);
      if (n == 1) check("t1_vld_next_edge", out_vld, 1);
    end
    in_vld = '0;
    wait_drain("t1_drained", 20);
    check("t1_hs_count", hs_log.size(), 4);
    check("t1_consecutive", (hs_log.size() == 4) ? hs_log[3] - hs_log[0] : -1, 3);

    // 2: all channels at once, round-robin 0,1,2,3
    do_reset();
    smp_en = 1'b1; out_rdy = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      in_vld = 4'hF;
      for (int i = 0; i < NCH; i++) begin
        set_ch(i, 32'h10 * i + n);
        exp_q.push_back(ent(i, 32'h10 * i + n));
      end
      tick();
    end
    in_vld = '0;
    wait_drain("t2_drained", 40);
    check("t2_ovf", ovf, 0);

    // 3: fill ch1 with output stalled, then overflow
    do_reset();
    smp_en = 1'b1;
    tick();
    for (int n = 0; n < 19; n++) begin
      in_vld = 4'b0010;
      set_ch(1, 32'h1000 + n);
      if (n < 17) exp_q.push_back(ent(1, 32'h1000 + n));
      tick();
      if (n == 16) check("t3_no_ovf_at_17", ovf, 0);
    end
    in_vld = '0;
    check("t3_ovf_set", ovf, 4'b0010);
    out_rdy = 1'b1;
    wait_drain("t3_drained", 60);
    check("t3_ovf_sticky", ovf, 4'b0010);
    smp_en = 1'b0;
    wait_done("t3_done", 10);
    check("t3_ovf_in_done", ovf, 4'b0010);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    check("t3_ovf_clr", ovf, 0);
    check("t3_done_clr", done, 0);

    // 4: per-channel limit of 5, all channels reach it and drain to done
    do_reset();
    max_cnt = 16'd5; smp_en = 1'b1; out_rdy = 1'b1;
    tick();
    for (int n = 0; n < 8; n++) begin
      in_vld = 4'hF;
      for (int i = 0; i < NCH; i++) begin
        set_ch(i, 32'h100 * i + n);
        if (n < 5) exp_q.push_back(ent(i, 32'h100 * i + n));
      end
      tick();
    end
    in_vld = '0;
    wait_drain("t4_drained", 60);
    check("t4_ovf", ovf, 0);
    wait_done("t4_done", 10);
    check("t4_vld_in_done", out_vld, 0);

    // 5: clr mid-run discards buffered data; async reset clears outputs at once
    do_reset();
    smp_en = 1'b1;
    tick();
    for (int n = 0; n < 3; n++) begin
      in_vld = 4'b0001;
      set_ch(0, 32'h500 + n);
      tick();
    end
    in_vld = '0;
    check("t5_vld_before_clr", out_vld, 1);
    clr = 1'b1;
    tick();
    clr = 1'b0; smp_en = 1'b0; out_rdy = 1'b1;
    check("t5_vld_after_clr", out_vld, 0);
    check("t5_ovf_after_clr", ovf, 0);
    check("t5_done_after_clr", done, 0);
    repeat (6) tick();
    check("t5_quiet", out_vld, 0);
    smp_en = 1'b1; out_rdy = 1'b0;
    tick();
    in_vld = 4'b1000;
    set_ch(3, 32'hDEADBEEF);
    tick();
    in_vld = '0;
    tick();
    check("t5_loaded_data", out_data, 32'hDEADBEEF);
    check("t5_loaded_ch", out_ch, 3);
    #3;
    rst_n = 1'b0;
    #1;
    check("t5_arst_vld", out_vld, 0);
    check("t5_arst_data", out_data, 0);
    check("t5_arst_ch", out_ch, 0);
    check("t5_arst_done", done, 0);
    tick();
    rst_n = 1'b1;

`ifdef SMP_CAP_TS_EN
    // 6: timestamps captured at RUN cycles 4 and 9
    do_reset();
    smp_en = 1'b1;
    tick();
    repeat (4) tick();
    in_vld = 4'b1000;
    set_ch(3, 32'h300);
    exp_q.push_back(ent(3, 32'h300));
    tick();
    in_vld = '0;
    tick();
    check("t6_ts_first", out_ts, 4);
    out_rdy = 1'b1;
    tick();
    out_rdy = 1'b0;
    repeat (2) tick();
    in_vld = 4'b1000;
    set_ch(3, 32'h301);
    exp_q.push_back(ent(3, 32'h301));
    tick();
    in_vld = '0;
    tick();
    check("t6_ts_second", out_ts, 9);
    out_rdy = 1'b1;
    wait_drain("t6_drained", 10);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
